// File: rtl/sample_packer.sv
// sample_packer: packs SAMPLE_WIDTH-bit samples into BUS_WIDTH-bit bus words.
// Optional internal ramp source is built only with PACKER_TESTPATTERN_EN.
module sample_packer #(
   parameter int SAMPLE_WIDTH = 10,
   parameter int BUS_WIDTH    = 16
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    mode,
   input  logic [SAMPLE_WIDTH-1:0] sampleIn,
   input  logic                    sampleValid,
   output logic                    sampleReady,
   input  logic                    flush,
   output logic                    flushDone,
   input  logic                    testMode,
   output logic [BUS_WIDTH-1:0]    wordOut,
   output logic                    wordValid,
   input  logic                    wordReady,
   output logic                    overflow
);
   localparam int ACC_W = BUS_WIDTH + SAMPLE_WIDTH - 1;
   localparam int CW    = $clog2(ACC_W + BUS_WIDTH + 1);
   localparam logic [CW-1:0] L_BW  = CW'(BUS_WIDTH);
   localparam logic [CW-1:0] L_SW  = CW'(SAMPLE_WIDTH);
   localparam logic [CW-1:0] L_ACC = CW'(ACC_W);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FLUSH
   } state_t;

   state_t                  r_state, w_state;
   logic [ACC_W-1:0]        r_acc, w_acc;
   logic [CW-1:0]           r_cnt, w_cnt;
   logic                    r_mode, w_mode;
   logic [BUS_WIDTH-1:0]    r_word, w_word;
   logic                    r_wvalid, w_wvalid;
   logic                    r_ovf, w_ovf;
   logic                    r_done, w_done;
   logic [SAMPLE_WIDTH-1:0] w_sample;
   logic                    w_free, w_e0, w_e1, w_take;
   logic [ACC_W-1:0]        w_acc_e, w_cat;
   logic [CW-1:0]           w_cnt_e, w_tot;

`ifdef PACKER_TESTPATTERN_EN
   logic [SAMPLE_WIDTH-1:0] r_ramp;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         r_ramp <= '0;
      else if (w_take)
         r_ramp <= r_ramp + SAMPLE_WIDTH'(1);
   end

   assign w_sample = testMode ? r_ramp : sampleIn;
`else
   logic w_unused;
   assign w_unused = testMode;
   assign w_sample = sampleIn;
`endif

   // Drain a stored full word first, then merge the new sample; if no
   // stored word went out, the merged bits may form this cycle's word.
   always_comb begin
      w_state  = r_state;
      w_mode   = (r_state == IDLE) ? mode : r_mode;
      w_done   = 1'b0;
      w_free   = !r_wvalid || wordReady;
      w_e0     = (r_cnt >= L_BW) && w_free;
      w_acc_e  = w_e0 ? (r_acc >> BUS_WIDTH) : r_acc;
      w_cnt_e  = w_e0 ? (r_cnt - L_BW) : r_cnt;
      sampleReady = !reset && (r_state != FLUSH) &&
                    (w_cnt_e + L_SW <= L_ACC);
      w_take   = sampleValid && sampleReady;
      w_cat    = w_acc_e;
      w_tot    = w_cnt_e;
      if (w_take) begin
         w_cat = w_acc_e | (ACC_W'(w_sample) << w_cnt_e);
         w_tot = w_cnt_e + (w_mode ? L_SW : L_BW);
      end
      w_e1 = !w_e0 && w_free &&
             ((w_tot >= L_BW) ||
              ((r_state == FLUSH) && (w_tot != '0)));
      w_acc    = w_cat;
      w_cnt    = w_tot;
      w_word   = r_word;
      w_wvalid = r_wvalid && !wordReady;
      if (w_e0) begin
         w_word   = r_acc[BUS_WIDTH-1:0];
         w_wvalid = 1'b1;
      end
      if (w_e1) begin
         w_word   = w_cat[BUS_WIDTH-1:0];
         w_wvalid = 1'b1;
         w_acc    = w_cat >> BUS_WIDTH;
         w_cnt    = (w_tot >= L_BW) ? (w_tot - L_BW) : '0;
      end
      w_ovf = r_ovf ||
              ((r_state == RUN) && sampleValid && !sampleReady);
      unique case (r_state)
         IDLE: begin
            if (w_take && flush)
               w_state = FLUSH;
            else if (w_take)
               w_state = RUN;
            else if (flush)
               w_done = 1'b1;
         end
         RUN: begin
            if (flush)
               w_state = FLUSH;
         end
         FLUSH: begin
            if ((r_cnt == '0) && w_free) begin
               w_done  = 1'b1;
               w_cnt   = '0;
               w_state = IDLE;
            end
         end
         default: w_state = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_mode   <= 1'b0;
         r_word   <= '0;
         r_wvalid <= 1'b0;
         r_ovf    <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_acc    <= w_acc;
         r_cnt    <= w_cnt;
         r_mode   <= w_mode;
         r_word   <= w_word;
         r_wvalid <= w_wvalid;
         r_ovf    <= w_ovf;
         r_done   <= w_done;
      end
   end

   assign wordOut   = r_word;
   assign wordValid = r_wvalid;
   assign overflow  = r_ovf;
   assign flushDone = r_done;

endmodule

// File: doc/sample_packer.md
Name: sample_packer

Overview:
Single-clock sample-to-bus packer between the sample source (ADC or test generator) and the capture FIFO. It converts SAMPLE_WIDTH-bit samples into BUS_WIDTH-bit words for the FX3 databus, in one of two modes:
- unpacked: one sample per word.
- packed: a dense LSB-first bitstream, so 10-bit RF samples use 10/16 of the USB bandwidth.

Valid/ready handshakes are used on both sides. A flush pads out the final partial word.

Parameters:
SAMPLE_WIDTH, 10, input sample width in bits; must satisfy 1 <= SAMPLE_WIDTH <= BUS_WIDTH.
BUS_WIDTH, 16, output word width in bits.

Ports:
clock  input  1  packer clock (sample clock domain)
reset  input  1  asynchronous, active-high reset
mode  input  1  0 = unpacked, 1 = packed; latched only in IDLE
sampleIn  input  SAMPLE_WIDTH  input sample
sampleValid  input  1  sampleIn valid this cycle
sampleReady  output  1  packer accepts sampleIn this cycle
flush  input  1  pulse: emit residue zero-padded, then return to IDLE
flushDone  output  1  one-cycle pulse when flush completes
testMode  input  1  selects internal ramp (only with PACKER_TESTPATTERN_EN)
wordOut  output  BUS_WIDTH  output word
wordValid  output  1  wordOut valid
wordReady  input  1  downstream accepts wordOut
overflow  output  1  sticky: a sample was offered while sampleReady=0 in RUN

Behaviour:
- Reset values: all outputs 0; accumulator and bit count 0; latched mode 0; state IDLE.
- Accumulator: ACC_W = BUS_WIDTH+SAMPLE_WIDTH-1 bits; bitCount ranges 0..ACC_W.
- States:
  - IDLE: bitCount=0 and output register empty. Latch mode every cycle. On the first accepted sample, go to RUN.
  - RUN: normal operation.
  - FLUSH: entered when flush=1 in RUN; in IDLE, flush produces only a flushDone pulse on the next cycle.
- Accept rule: a sample is accepted when sampleValid && sampleReady. sampleReady=1 in IDLE/RUN when bitCount + SAMPLE_WIDTH <= ACC_W, evaluated after this cycle's emission. sampleReady=0 in FLUSH.
- Packed mode:
  - Sample bit 0 goes to accumulator bit position bitCount (LSB-first bitstream).
  - When bitCount >= BUS_WIDTH and the output register is free (empty, or wordReady=1 this cycle), load wordOut with accumulator bits [BUS_WIDTH-1:0], shift the accumulator right by BUS_WIDTH, and subtract BUS_WIDTH from bitCount.
  - Emission and acceptance may occur in the same cycle.
- Unpacked mode:
  - wordOut = {zeros, sample}; bitCount is rounded up to BUS_WIDTH per sample.
  - Sustains 1 word/cycle when wordReady=1.
- Latency: first word is available 1 cycle after the accept that fills BUS_WIDTH bits (registered output).
- Output handshake:
  - wordOut/wordValid are held stable until wordReady=1.
  - wordValid=1 with wordReady=1 completes a transfer; a new word may load in the same cycle.
- FLUSH:
  - Inputs are ignored, and no overflow is flagged while in FLUSH.
  - Drain all full words.
  - If 0 < bitCount < BUS_WIDTH, emit one word with the residue in the low bits and zeros above.
  - When the accumulator and output register are empty, pulse flushDone, set bitCount=0 and go to IDLE.
- overflow: set when sampleValid=1 && sampleReady=0 in RUN; the dropped sample is lost. Cleared only by reset.
- Simultaneous flush and sampleValid in RUN: the sample is accepted first, then the block enters FLUSH.
- A mode change in RUN is ignored until the next IDLE.
- Reset mid-operation: immediately return to the reset values and discard partial data.

Optional Feature:
PACKER_TESTPATTERN_EN
- Defined: when testMode=1, sampleIn is replaced by an internal SAMPLE_WIDTH-bit ramp counter. The counter starts at 0 after reset and increments (wrapping) on each accepted sample; sampleValid is still honoured.
- Undefined: testMode is ignored, no counter logic is built, and sampleIn is always used.

Test Plan:
- Packed, SAMPLE_WIDTH=10, BUS_WIDTH=16, wordReady=1, samples 0x001..0x008 back-to-back -> exactly 5 words in order: 0x0801, 0x0030, 0x0501, 0x7018, 0x0200; no flushDone; overflow=0.
- Unpacked, samples 0x3FF, 0x155 -> words 0x03FF, 0x0155, each one cycle after its accept.
- Packed, 3 samples 0x3FF then flush pulse -> words 0xFFFF, 0x3FFF, then flushDone pulse one cycle after the last transfer; state back to IDLE with bitCount=0.
- Packed, wordReady=0 held, continuous sampleValid -> wordOut stable at the first word, sampleReady drops to 0, overflow sets and stays 1 after wordReady returns to 1.
- Assert reset mid-stream with 5 bits residual -> next cycle all outputs 0; subsequent samples packed from bit 0.
- With PACKER_TESTPATTERN_EN, testMode=1, unpacked, 1030 accepts -> words 0x0000..0x03FF, then 0x0000..0x0005 (wrap).
